pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register; generalises the IF/ID latch to any stage pair.
//  - Carries a PC word and an instruction word with a valid/ready handshake.
//  - A 2-entry skid buffer keeps up_ready registered, cutting the stall path.
//  - flush squashes the stage to a NOP bubble; a saturating counter records issued bubbles.

---
 rtl/mips_pipe_pkg.sv | 15 +
 rtl/pipe_skid_slot.sv | 19 +
 rtl/pipe_stage_reg.sv | 126 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared constants and stage state encoding for the MIPS pipeline
// inter-stage registers.
package mips_pipe_pkg;

  // add $0,$0,$0 -- the canonical bubble
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0020;
  localparam logic [31:0] RST_PC_DEF    = 32'h0000_0004;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    BOTH  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload entry of the stage: a register that either loads d or holds,
// with a configurable reset image.
module pipe_skid_slot #(
  parameter int           W       = 64,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= RST_VAL;
    else if (load) q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer so up_ready comes
// straight from flops; flush squashes to a NOP bubble, bubbles are counted.
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
  parameter logic [PC_W-1:0]    RST_PC    = PC_W'(RST_PC_DEF),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [PC_W-1:0]    up_pc,
  input  logic [INSTR_W-1:0] up_instr,
  output logic               dn_valid,
  input  logic               dn_ready,
  output logic [PC_W-1:0]    dn_pc,
  output logic [INSTR_W-1:0] dn_instr,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam int PW = PC_W + INSTR_W;

  stage_state_e  state, state_nxt;
  logic          up_xfer;
  logic          main_load, skid_load;
  logic [PW-1:0] main_d, main_q, skid_q;

  assign up_xfer = up_valid & up_ready;

  // Next-state and entry-load decode. Flush overrides everything: the
  // incoming word is dropped, the skid entry is abandoned, and the main
  // entry becomes a bubble that still tracks the upstream PC.
  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = {up_pc, up_instr};
    if (flush) begin
      state_nxt = EMPTY;
      main_load = 1'b1;
      main_d    = {up_pc, NOP_INSTR};
    end else begin
      case (state)
        EMPTY: begin
          if (up_xfer) begin
            main_load = 1'b1;
            state_nxt = FULL;
          end
        end
        FULL: begin
          if (dn_ready) begin
            main_load = 1'b1;
            if (!up_xfer) begin
              // draining to empty: keep the PC, show a bubble
              main_d    = {main_q[PW-1:INSTR_W], NOP_INSTR};
              state_nxt = EMPTY;
            end
          end else if (up_xfer) begin
            skid_load = 1'b1;
            state_nxt = BOTH;
          end
        end
        BOTH: begin
          // up_ready is low here, so up_valid cannot transfer
          if (dn_ready) begin
            main_load = 1'b1;
            main_d    = skid_q;
            state_nxt = FULL;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      dn_valid <= 1'b0;
      up_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      dn_valid <= (state_nxt != EMPTY);
      up_ready <= (state_nxt != BOTH);
    end
  end

  pipe_skid_slot #(
    .W       (PW),
    .RST_VAL ({RST_PC, NOP_INSTR})
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_skid_slot #(
    .W       (PW),
    .RST_VAL ({RST_PC, NOP_INSTR})
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .d     ({up_pc, up_instr}),
    .q     (skid_q)
  );

  assign dn_pc    = main_q[PW-1:INSTR_W];
  assign dn_instr = main_q[INSTR_W-1:0];

  // A bubble is counted whenever downstream was ready but got nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_cnt <= '0;
    else if (!dn_valid && dn_ready && (bubble_cnt != {CNT_W{1'b1}}))
      bubble_cnt <= bubble_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted upstream words are queued and
// must emerge downstream in order; flush discards everything still queued.
module tb_pipe_stage_reg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 2;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0020;

  logic               clk = 1'b0;
  logic               rst_n, flush, up_valid, up_ready, dn_valid, dn_ready;
  logic [PC_W-1:0]    up_pc, dn_pc;
  logic [INSTR_W-1:0] up_instr, dn_instr;
  logic [CNT_W-1:0]   bubble_cnt;

  int checks = 0;
  int errors = 0;
  logic [PC_W+INSTR_W-1:0] sb[$];

  pipe_stage_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_pc      (up_pc),
    .up_instr   (up_instr),
    .dn_valid   (dn_valid),
    .dn_ready   (dn_ready),
    .dn_pc      (dn_pc),
    .dn_instr   (dn_instr),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so at negedge they are stable and describe
  // exactly the transfers that happen on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (!dn_valid) begin
        checks++;
        if (dn_instr !== NOP) begin
          errors++;
          $display("FAIL bubble_instr: dn_instr=%h required %h", dn_instr, NOP);
        end
      end
      if (dn_valid && dn_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got pc=%h instr=%h, required no output", dn_pc, dn_instr);
        end else begin
          logic [PC_W+INSTR_W-1:0] exp;
          exp = sb.pop_front();
          if ({dn_pc, dn_instr} !== exp) begin
            errors++;
            $display("FAIL sb_data: got %h_%h required %h_%h", dn_pc, dn_instr,
                     exp[PC_W+INSTR_W-1:INSTR_W], exp[INSTR_W-1:0]);
          end
        end
      end
      if (flush) sb.delete();
      else if (up_valid && up_ready) sb.push_back({up_pc, up_instr});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [PC_W-1:0] pc);
    up_valid = 1'b1;
    up_pc    = pc;
    up_instr = 32'hA500_0000 | pc;
  endtask

  task automatic test_bubble_sat();
    logic [CNT_W-1:0] exp;
    rst_n = 1'b0; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
    up_pc = '0; up_instr = '0;
    step();
    checks++;
    if (bubble_cnt !== '0) begin
      errors++; $display("FAIL cnt_reset: got %0d required 0", bubble_cnt);
    end
    rst_n = 1'b1;
    step();
    dn_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      exp = (i < 3) ? CNT_W'(i + 1) : CNT_W'(3);
      checks++;
      if (bubble_cnt !== exp) begin
        errors++; $display("FAIL cnt_sat[%0d]: got %0d required %0d", i, bubble_cnt, exp);
      end
    end
  endtask

  task automatic test_reset();
    dn_ready = 1'b0;
    offer(32'h100);
    step();
    up_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (dn_valid !== 1'b0 || dn_pc !== 32'h4 || dn_instr !== NOP ||
        up_ready !== 1'b1 || bubble_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b pc=%h instr=%h rdy=%b cnt=%0d required 0/4/20/1/0",
               dn_valid, dn_pc, dn_instr, up_ready, bubble_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [PC_W-1:0] pcs [3];
    pcs[0] = 32'h8; pcs[1] = 32'hC; pcs[2] = 32'h10;
    dn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(pcs[i]);
      step();
      checks++;
      if (dn_valid !== 1'b1 || dn_pc !== pcs[i] || dn_instr !== (32'hA500_0000 | pcs[i]) ||
          up_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h rdy=%b required pc=%h", i,
                 dn_valid, dn_pc, dn_instr, up_ready, pcs[i]);
      end
    end
    up_valid = 1'b0;
    step();
    checks++;
    if (dn_valid !== 1'b0) begin
      errors++; $display("FAIL stream_drain: dn_valid=%b required 0", dn_valid);
    end
  endtask

  task automatic test_stall_skid();
    dn_ready = 1'b0;
    offer(32'h8);
    step();
    offer(32'hC);
    step();
    up_valid = 1'b0;
    checks++;
    if (up_ready !== 1'b0 || dn_valid !== 1'b1 || dn_pc !== 32'h8) begin
      errors++;
      $display("FAIL stall_hold: rdy=%b valid=%b pc=%h required 0/1/8", up_ready, dn_valid, dn_pc);
    end
    dn_ready = 1'b1;
    step();
    checks++;
    if (dn_valid !== 1'b1 || dn_pc !== 32'hC || up_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: valid=%b pc=%h rdy=%b required 1/c/1", dn_valid, dn_pc, up_ready);
    end
    step();
    checks++;
    if (dn_valid !== 1'b0) begin
      errors++; $display("FAIL stall_drain: dn_valid=%b required 0", dn_valid);
    end
  endtask

  task automatic test_flush_both();
    dn_ready = 1'b0;
    offer(32'h50);
    step();
    offer(32'h54);
    step();
    up_valid = 1'b0;
    up_pc    = 32'h40;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (dn_valid !== 1'b0 || dn_instr !== NOP || dn_pc !== 32'h40 || up_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_both: valid=%b instr=%h pc=%h rdy=%b required 0/20/40/1",
               dn_valid, dn_instr, dn_pc, up_ready);
    end
    dn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dn_valid !== 1'b0) begin
        errors++; $display("FAIL flush_skid_leak[%0d]: dn_valid=%b pc=%h required 0", i, dn_valid, dn_pc);
      end
    end
  endtask

  task automatic test_flush_xfer();
    dn_ready = 1'b1;
    offer(32'h60);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (dn_valid !== 1'b0 || dn_pc !== 32'h60) begin
      errors++; $display("FAIL flush_drop: valid=%b pc=%h required 0/60", dn_valid, dn_pc);
    end
    offer(32'h64);
    step();
    up_valid = 1'b0;
    checks++;
    if (dn_valid !== 1'b1 || dn_pc !== 32'h64 || dn_instr !== (32'hA500_0000 | 32'h64)) begin
      errors++; $display("FAIL flush_next: valid=%b pc=%h instr=%h required 1/64", dn_valid, dn_pc, dn_instr);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [PC_W-1:0] pc;
    int budget;
    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      offer(pc);
      up_valid = ($urandom_range(3) != 0);
      dn_ready = ($urandom_range(2) != 0);
      flush    = ($urandom_range(31) == 0);
      if (up_valid && up_ready) pc = pc + 32'h4;
      step();
    end
    up_valid = 1'b0;
    flush    = 1'b0;
    dn_ready = 1'b1;
    budget   = 0;
    while (sb.size() != 0 && budget < 10) begin
      step();
      budget++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL b2b_drain: %0d words left after timeout, required 0", sb.size());
    end
  endtask

  initial begin
    test_bubble_sat();
    test_reset();
    test_stream();
    test_stall_skid();
    test_flush_both();
    test_flush_xfer();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
